// File: rtl/booth_r8_pkg.sv
// booth_r8_pkg: shared types and sizing helper for the radix-8 Booth multipliers
//   state_t : sequential controller states
//   sel_t   : one-hot digit magnitude {a=1x, b=2x, c=3x, d=4x} plus sign
//   nd_of   : number of radix-8 digits for an n-bit unsigned multiplier
package booth_r8_pkg;

    typedef enum logic [1:0] {IDLE, PRECOMP, ITER, DONE} state_t;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic neg;
    } sel_t;

    // ceil((n+1)/3): the extra bit keeps the top digit non-negative for unsigned operands
    function automatic int nd_of(input int n);
        return (n + 3) / 3;
    endfunction

endpackage

// File: rtl/booth_enc_r8.sv
// booth_enc_r8: radix-8 Booth digit encoder
//   grp : {y[3i+2], y[3i+1], y[3i], y[3i-1]}
//   sel : one-hot magnitude {a,b,c,d} and sign; the digit value 0 selects nothing
module booth_enc_r8
    import booth_r8_pkg::*;
(
    input  logic [3:0] grp,
    output sel_t       sel
);

    logic [2:0] h;
    logic [2:0] mag;

    // digit(g) = -digit(~g), so negative groups are folded onto their positive mirror
    always_comb begin
        h       = grp[3] ? ~grp[2:0] : grp[2:0];
        mag     = {1'b0, h[2], 1'b0} + {2'b0, h[1]} + {2'b0, h[0]};
        sel.a   = mag == 3'd1;
        sel.b   = mag == 3'd2;
        sel.c   = mag == 3'd3;
        sel.d   = mag == 3'd4;
        sel.neg = grp[3] && mag != 3'd0;
    end

endmodule

// File: rtl/booth_r8_seq_mul.sv
// booth_r8_seq_mul: sequential radix-8 Booth multiplier, one digit per cycle
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake, x_in/y_in sampled on acceptance
//   out_valid/out_ready  : product handshake, prod held while out_ready=0
//   prod                 : unsigned product x*y (2N bits)
//   busy                 : high in PRECOMP or ITER
module booth_r8_seq_mul
    import booth_r8_pkg::*;
#(
    parameter int N          = 24,
    parameter int ND         = nd_of(N),
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x_in,
    input  logic [N-1:0]   y_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic           busy
);

    localparam int AW = 2 * N + 3;
    localparam int PW = N + 3;
    localparam int YW = 3 * ND + 1;
    localparam int CW = $clog2(ND + 1);
    localparam int SW = $clog2(YW);

    state_t        state, state_nxt;
    logic [N-1:0]  xr;
    logic [N+1:0]  x3;
    logic [YW-1:0] ye;
    logic [AW-1:0] acc, acc_nxt, pp_ext;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sh;
    logic [PW-1:0] mag, ppv;
    logic [3:0]    grp;
    logic          accept, last;
    sel_t          sel;

    booth_enc_r8 u_enc (.grp(grp), .sel(sel));

    // acc is a two's-complement running sum; low digits may drive it negative
    always_comb begin
        sh      = SW'(3 * cnt);
        grp     = ye[sh +: 4];
        mag     = sel.a ? {3'b0, xr} :
                  sel.b ? {2'b0, xr, 1'b0} :
                  sel.c ? {1'b0, x3} :
                  sel.d ? {1'b0, xr, 2'b0} : '0;
        ppv     = mag ^ {PW{sel.neg}};
        pp_ext  = {{(AW - PW){ppv[PW-1]}}, ppv};
        acc_nxt = acc + (pp_ext << sh) + (AW'(sel.neg) << sh);
        last    = cnt == CW'(ND - 1) || (EARLY_EXIT && (ye >> (32'(sh) + 3)) == '0);
        accept  = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? PRECOMP : IDLE;
            PRECOMP: state_nxt = ITER;
            ITER:    state_nxt = last ? DONE : ITER;
            DONE:    state_nxt = accept ? PRECOMP : out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE || (state == DONE && out_ready);
        out_valid = state == DONE;
        busy      = state == PRECOMP || state == ITER;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr   <= '0;
            x3   <= '0;
            ye   <= '0;
            acc  <= '0;
            cnt  <= '0;
            prod <= '0;
        end else begin
            if (accept) begin
                xr  <= x_in;
                ye  <= {{(YW - N - 1){1'b0}}, y_in, 1'b0};
                acc <= '0;
                cnt <= '0;
            end
            if (state == PRECOMP)
                x3 <= {2'b0, xr} + {1'b0, xr, 1'b0};
            if (state == ITER) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (last)
                    prod <= acc_nxt[2*N-1:0];
            end
        end
    end

endmodule
